spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 134 +++++++++++++
 tb/tb_spi_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 master that sends {rw, addr, wdata} frames and captures read data
module spi_controller #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 7,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME = 1 + ADDR_W + WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic [FRAME-1:0]  tx_q;
  logic [WIDTH-1:0]  rx_q;
  logic              rw_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              mosi_q;
  logic [FRAME-1:0]  frame_d;

  // Reads put zeros in the data field regardless of wdata.
  assign frame_d = {rw, addr, rw ? {WIDTH{1'b0}} : wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle is spent in IDLE; a start there is dropped.
          if (start && !done_q) begin
            rw_q    <= rw;
            tx_q    <= {frame_d[FRAME-2:0], 1'b0};
            mosi_q  <= frame_d[FRAME-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (div_q == DIV_MAX) begin
            div_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (div_q == DIV_MAX) begin
            div_q <= '0;
            if (sclk_q) begin
              // Falling edge: sample MISO at the end of the high half, advance MOSI.
              sclk_q <= 1'b0;
              rx_q   <= {rx_q[WIDTH-2:0], spi_miso};
              mosi_q <= tx_q[FRAME-1];
              tx_q   <= {tx_q[FRAME-2:0], 1'b0};
            end else if (bit_q == BIT_MAX) begin
              bit_q   <= '0;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              state_q <= GAP;
            end else begin
              bit_q  <= bit_q + 1'b1;
              sclk_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP: begin
          if (div_q == DIV_MAX) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (rw_q) begin
              rdata_q <= rx_q;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, spi_cs_n, spi_clk, spi_mosi;
  logic [7:0] rdata;
  logic       spi_miso = 1'b0;

  int pass_cnt = 0;
  int total = 0;

  // Peripheral monitor/model, sampled on the falling clk edge.
  int          edges = 0;
  int          fe = 0;
  int          cs_low = 0;
  int          done_cnt = 0;
  int          high_run = 0;
  int          last_high = 0;
  logic [15:0] cap = '0;
  logic [15:0] miso_word = '0;
  logic        sclk_prev = 1'b0;

  spi_controller dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_cs_n) begin
      fe = 0;
      high_run = high_run + 1;
    end else begin
      cs_low = cs_low + 1;
      if (high_run != 0) last_high = high_run;
      high_run = 0;
    end
    if (spi_clk && !sclk_prev) begin
      edges = edges + 1;
      fe = fe + 1;
      cap = {cap[14:0], spi_mosi};
      spi_miso = (fe <= 16) ? miso_word[16-fe] : 1'b0;
    end
    if (done) done_cnt = done_cnt + 1;
    sclk_prev = spi_clk;
  end

  task automatic run_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                           input int stall_at, input int stall_len, input int p1, input int p2,
                           output int lat, output logic frz_ok, output logic busy_acc);
    logic [12:0] snap;
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    rw = ~r; addr = ~a; wdata = ~d;
    lat = 0;
    frz_ok = 1'b1;
    while (!done && lat < 1000) begin
      if (lat == stall_at) begin
        ena = 1'b0;
        snap = {spi_cs_n, spi_clk, spi_mosi, busy, done, rdata};
        repeat (stall_len) begin
          @(posedge clk); #1;
          lat++;
          if ({spi_cs_n, spi_clk, spi_mosi, busy, done, rdata} !== snap) frz_ok = 1'b0;
        end
        ena = 1'b1;
      end
      @(posedge clk); #1;
      lat++;
      start = (lat == p1 || lat == p2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if ({spi_cs_n, spi_clk, spi_mosi, busy, done} !== 5'b10000) begin
      $display("FAIL reset_ctl: got cs/clk/mosi/busy/done=%b want 10000", {spi_cs_n, spi_clk, spi_mosi, busy, done});
    end else pass_cnt++;
    total++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_write();
    int lat, e0, c0, d0;
    logic frz, bacc;
    e0 = edges; c0 = cs_low; d0 = done_cnt;
    run_frame(1'b0, 7'h05, 8'hA5, -1, 0, -1, -1, lat, frz, bacc);
    total++;
    if (bacc !== 1'b1) $display("FAIL wr_busy_accept: got %b want 1", bacc); else pass_cnt++;
    total++;
    if (lat !== 136) $display("FAIL wr_latency: got %0d want 136", lat); else pass_cnt++;
    total++;
    if (busy !== 1'b0) $display("FAIL wr_busy_done: got %b want 0", busy); else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (cap !== 16'h05A5) $display("FAIL wr_mosi: got %h want 05a5", cap); else pass_cnt++;
    total++;
    if (edges - e0 !== 16) $display("FAIL wr_edges: got %0d want 16", edges - e0); else pass_cnt++;
    total++;
    if (cs_low - c0 !== 132) $display("FAIL wr_cs_low: got %0d want 132", cs_low - c0); else pass_cnt++;
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL wr_done_cnt: got %0d want 1", done_cnt - d0); else pass_cnt++;
    total++;
    if (rdata !== 8'h00) $display("FAIL wr_rdata: got %h want 00", rdata); else pass_cnt++;
  endtask

  task automatic test_read();
    int lat;
    logic frz, bacc;
    miso_word = 16'h003C;
    run_frame(1'b1, 7'h02, 8'hFF, -1, 0, -1, -1, lat, frz, bacc);
    total++;
    if (lat !== 136) $display("FAIL rd_latency: got %0d want 136", lat); else pass_cnt++;
    total++;
    if (rdata !== 8'h3C) $display("FAIL rd_rdata_done: got %h want 3c", rdata); else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (cap !== 16'h8200) $display("FAIL rd_mosi: got %h want 8200", cap); else pass_cnt++;
    total++;
    if (rdata !== 8'h3C) $display("FAIL rd_rdata_hold: got %h want 3c", rdata); else pass_cnt++;
    miso_word = 16'h0000;
  endtask

  task automatic test_ignore_start();
    int lat, e0, d0;
    logic frz, bacc;
    e0 = edges; d0 = done_cnt;
    run_frame(1'b0, 7'h15, 8'hC3, -1, 0, 10, 70, lat, frz, bacc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({busy, spi_cs_n} !== 2'b01) $display("FAIL ign_done_start: got busy/cs=%b want 01", {busy, spi_cs_n}); else pass_cnt++;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (lat !== 136) $display("FAIL ign_latency: got %0d want 136", lat); else pass_cnt++;
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL ign_done_cnt: got %0d want 1", done_cnt - d0); else pass_cnt++;
    total++;
    if (edges - e0 !== 16) $display("FAIL ign_edges: got %0d want 16", edges - e0); else pass_cnt++;
    total++;
    if (cap !== 16'h15C3) $display("FAIL ign_mosi: got %h want 15c3", cap); else pass_cnt++;
  endtask

  task automatic test_ena_stall();
    int lat;
    logic frz, bacc;
    run_frame(1'b0, 7'h6B, 8'h0F, 50, 20, -1, -1, lat, frz, bacc);
    total++;
    if (frz !== 1'b1) $display("FAIL ena_freeze: got %b want 1", frz); else pass_cnt++;
    total++;
    if (lat !== 156) $display("FAIL ena_latency: got %0d want 156", lat); else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (cap !== 16'h6B0F) $display("FAIL ena_mosi: got %h want 6b0f", cap); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic frz, bacc;
    run_frame(1'b0, 7'h11, 8'h22, -1, 0, -1, -1, lat, frz, bacc);
    @(posedge clk); #1;
    rw = 1'b0; addr = 7'h44; wdata = 8'h99; start = 1'b1;
    total++;
    if (spi_cs_n !== 1'b1) $display("FAIL b2b_cs_early: got %b want 1", spi_cs_n); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({spi_cs_n, busy} !== 2'b01) $display("FAIL b2b_cs_fall: got cs/busy=%b want 01", {spi_cs_n, busy}); else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (last_high !== 6) $display("FAIL b2b_cs_high: got %0d want 6", last_high); else pass_cnt++;
    n = 0;
    while (!done && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 136) $display("FAIL b2b_latency: got %0d want 136", n); else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (cap !== 16'h4499) $display("FAIL b2b_mosi: got %h want 4499", cap); else pass_cnt++;
    total++;
    if (rdata !== 8'h3C) $display("FAIL b2b_rdata_write: got %h want 3c", rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, e0, d0, n;
    logic frz, bacc;
    d0 = done_cnt; e0 = edges;
    @(negedge clk);
    rw = 1'b0; addr = 7'h7F; wdata = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (edges - e0 < 7 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (edges - e0 !== 7) $display("FAIL rstm_reach_edge7: got %0d want 7", edges - e0); else pass_cnt++;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({spi_cs_n, spi_clk, spi_mosi, busy, done} !== 5'b10000) begin
      $display("FAIL rstm_async: got cs/clk/mosi/busy/done=%b want 10000", {spi_cs_n, spi_clk, spi_mosi, busy, done});
    end else pass_cnt++;
    total++;
    if (rdata !== 8'h00) $display("FAIL rstm_rdata: got %h want 00", rdata); else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (done_cnt - d0 !== 0) $display("FAIL rstm_no_done: got %0d want 0", done_cnt - d0); else pass_cnt++;
    e0 = edges;
    run_frame(1'b0, 7'h33, 8'h5A, -1, 0, -1, -1, lat, frz, bacc);
    total++;
    if (lat !== 136) $display("FAIL rstm_latency: got %0d want 136", lat); else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (cap !== 16'h335A) $display("FAIL rstm_mosi: got %h want 335a", cap); else pass_cnt++;
    total++;
    if (edges - e0 !== 16) $display("FAIL rstm_edges: got %0d want 16", edges - e0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_ena_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
